branch_predictor: RTL and testbench

Parametrised dynamic branch predictor for the 5-stage pipeline. It replaces the fixed "predict not-taken, flush on branch" scheme. The IF stage looks up the fetch PC combinationally and receives a taken prediction plus the next-PC target. The ID stage writes back resolved branch outcomes, which train a table of saturating counters with tagged targets. Two saturating performance counters track resolved branches and mispredictions.

---
 rtl/branch_predictor.sv | 120 ++++++++++++
 tb/tb_branch_predictor.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: tagged table of saturating counters with targets,
// looked up combinationally by IF and trained by resolved branches from ID.
module branch_predictor #(
    parameter int IDX_W  = 4,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pred_en_i,
    input  logic [31:0]       lookup_pc_i,
    output logic              pred_taken_o,
    output logic [31:0]       pred_target_o,
    input  logic              upd_valid_i,
    input  logic [31:0]       upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [31:0]       upd_target_i,
    input  logic              upd_miss_i,
    output logic [PERF_W-1:0] br_cnt_o,
    output logic [PERF_W-1:0] miss_cnt_o
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'((1 << CNT_W) - 1);
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(1 << (CNT_W - 1));
    localparam logic [PERF_W-1:0] PERF_MAX   = '1;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [CNT_W-1:0]  cnt_q    [ENTRIES];

    logic [PERF_W-1:0] br_cnt_q;
    logic [PERF_W-1:0] miss_cnt_q;

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic              lk_hit;

    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic              up_hit;
    logic [CNT_W-1:0]  up_cnt;
    logic [CNT_W-1:0]  cnt_nxt;

    // Byte-offset bits of the update PC never address the table.
    logic              unused_pc_bits;
    assign unused_pc_bits = ^upd_pc_i[1:0];

    assign lk_idx = lookup_pc_i[IDX_W+1:2];
    assign lk_tag = lookup_pc_i[31:IDX_W+2];
    assign up_idx = upd_pc_i[IDX_W+1:2];
    assign up_tag = upd_pc_i[31:IDX_W+2];

    always_comb begin
        lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken_o  = pred_en_i && lk_hit && cnt_q[lk_idx][CNT_W-1];
        pred_target_o = lookup_pc_i + 32'd4;
        if (pred_taken_o) begin
            pred_target_o = target_q[lk_idx];
        end
    end

    // A taken branch that misses the entry replaces it at weakly-taken strength.
    always_comb begin
        up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_cnt  = cnt_q[up_idx];
        cnt_nxt = up_cnt;
        if (upd_taken_i) begin
            if (!up_hit) begin
                cnt_nxt = CNT_WEAK_T;
            end else if (up_cnt != CNT_MAX) begin
                cnt_nxt = up_cnt + CNT_W'(1);
            end
        end else if (up_hit && (up_cnt != '0)) begin
            cnt_nxt = up_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WEAK_NT;
            end
        end else if (upd_valid_i) begin
            if (upd_taken_i) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target_i;
                cnt_q[up_idx]    <= cnt_nxt;
            end else if (up_hit) begin
                cnt_q[up_idx]    <= cnt_nxt;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else if (upd_valid_i) begin
            if (br_cnt_q != PERF_MAX) begin
                br_cnt_q <= br_cnt_q + PERF_W'(1);
            end
            if (upd_miss_i && (miss_cnt_q != PERF_MAX)) begin
                miss_cnt_q <= miss_cnt_q + PERF_W'(1);
            end
        end
    end

    assign br_cnt_o   = br_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (IDX_W=4, CNT_W=2),
// with a second instance at PERF_W=4 for performance-counter saturation.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic        pred_en;
    logic [31:0] lookup_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_miss;

    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;

    logic        pred_taken4;
    logic [31:0] pred_target4;
    logic [3:0]  br_cnt4;
    logic [3:0]  miss_cnt4;

    int n_checks;
    int n_fail;

    branch_predictor #(.IDX_W(4), .CNT_W(2), .PERF_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .pred_en_i(pred_en),
        .lookup_pc_i(lookup_pc), .pred_taken_o(pred_taken),
        .pred_target_o(pred_target), .upd_valid_i(upd_valid),
        .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
        .upd_target_i(upd_target), .upd_miss_i(upd_miss),
        .br_cnt_o(br_cnt), .miss_cnt_o(miss_cnt)
    );

    branch_predictor #(.IDX_W(4), .CNT_W(2), .PERF_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .pred_en_i(pred_en),
        .lookup_pc_i(lookup_pc), .pred_taken_o(pred_taken4),
        .pred_target_o(pred_target4), .upd_valid_i(upd_valid),
        .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
        .upd_target_i(upd_target), .upd_miss_i(upd_miss),
        .br_cnt_o(br_cnt4), .miss_cnt_o(miss_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        upd_valid = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic tk,
                             input logic [31:0] tgt, input logic miss);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        upd_miss   = miss;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        lookup_pc = 32'h40;
        #1;
        n_checks++;
        if (pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_taken got=%0b exp=0", pred_taken);
        end
        n_checks++;
        if (pred_target !== 32'h44) begin
            n_fail++;
            $display("FAIL reset_target got=%h exp=00000044", pred_target);
        end
        n_checks++;
        if (br_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_br_cnt got=%0d exp=0", br_cnt);
        end
        n_checks++;
        if (miss_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_miss_cnt got=%0d exp=0", miss_cnt);
        end
    endtask

    task automatic test_train();
        do_update(32'h40, 1'b1, 32'h80, 1'b1);
        lookup_pc = 32'h40;
        #1;
        n_checks++;
        if (pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL train_taken got=%0b exp=1", pred_taken);
        end
        n_checks++;
        if (pred_target !== 32'h80) begin
            n_fail++;
            $display("FAIL train_target got=%h exp=00000080", pred_target);
        end
        n_checks++;
        if (br_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL train_br_cnt got=%0d exp=1", br_cnt);
        end
        n_checks++;
        if (miss_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL train_miss_cnt got=%0d exp=1", miss_cnt);
        end
        lookup_pc = 32'h44;
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h48) begin
            n_fail++;
            $display("FAIL train_other_idx got=%0b/%h exp=0/00000048",
                     pred_taken, pred_target);
        end
    endtask

    task automatic test_saturate_hysteresis();
        for (int i = 0; i < 3; i++) do_update(32'h40, 1'b1, 32'h80, 1'b0);
        do_update(32'h40, 1'b0, 32'h0, 1'b1);
        lookup_pc = 32'h40;
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
            n_fail++;
            $display("FAIL sat_one_nt got=%0b/%h exp=1/00000080",
                     pred_taken, pred_target);
        end
        do_update(32'h40, 1'b0, 32'h0, 1'b1);
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin
            n_fail++;
            $display("FAIL sat_two_nt got=%0b/%h exp=0/00000044",
                     pred_taken, pred_target);
        end
        n_checks++;
        if (br_cnt !== 32'd6 || miss_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL sat_perf got=%0d/%0d exp=6/3", br_cnt, miss_cnt);
        end
        do_update(32'h40, 1'b0, 32'h0, 1'b0);
        do_update(32'h40, 1'b0, 32'h0, 1'b0);
        do_update(32'h40, 1'b1, 32'h80, 1'b0);
        #1;
        n_checks++;
        if (pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_floor got=%0b exp=0", pred_taken);
        end
    endtask

    task automatic test_alias();
        do_reset();
        do_update(32'h40, 1'b1, 32'h80, 1'b0);
        lookup_pc = 32'h80;
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h84) begin
            n_fail++;
            $display("FAIL alias_lookup got=%0b/%h exp=0/00000084",
                     pred_taken, pred_target);
        end
        do_update(32'h80, 1'b0, 32'h0, 1'b0);
        lookup_pc = 32'h40;
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
            n_fail++;
            $display("FAIL alias_nt_no_alloc got=%0b/%h exp=1/00000080",
                     pred_taken, pred_target);
        end
        do_update(32'h80, 1'b1, 32'h100, 1'b1);
        lookup_pc = 32'h80;
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h100) begin
            n_fail++;
            $display("FAIL alias_replace got=%0b/%h exp=1/00000100",
                     pred_taken, pred_target);
        end
        lookup_pc = 32'h40;
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin
            n_fail++;
            $display("FAIL alias_evicted got=%0b/%h exp=0/00000044",
                     pred_taken, pred_target);
        end
        do_update(32'h80, 1'b0, 32'h0, 1'b1);
        lookup_pc = 32'h80;
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h84) begin
            n_fail++;
            $display("FAIL alias_weak_load got=%0b/%h exp=0/00000084",
                     pred_taken, pred_target);
        end
    endtask

    task automatic test_no_bypass();
        do_reset();
        lookup_pc  = 32'h40;
        upd_valid  = 1'b1;
        upd_pc     = 32'h40;
        upd_taken  = 1'b1;
        upd_target = 32'h80;
        upd_miss   = 1'b1;
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin
            n_fail++;
            $display("FAIL bypass_same_cycle got=%0b/%h exp=0/00000044",
                     pred_taken, pred_target);
        end
        tick();
        upd_valid = 1'b0;
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
            n_fail++;
            $display("FAIL bypass_next_cycle got=%0b/%h exp=1/00000080",
                     pred_taken, pred_target);
        end
    endtask

    task automatic test_pred_disable();
        do_reset();
        pred_en = 1'b0;
        do_update(32'h40, 1'b1, 32'h80, 1'b0);
        do_update(32'h40, 1'b1, 32'h80, 1'b1);
        lookup_pc = 32'h40;
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin
            n_fail++;
            $display("FAIL dis_forced_nt got=%0b/%h exp=0/00000044",
                     pred_taken, pred_target);
        end
        n_checks++;
        if (br_cnt !== 32'd2 || miss_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL dis_perf got=%0d/%0d exp=2/1", br_cnt, miss_cnt);
        end
        pred_en = 1'b1;
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
            n_fail++;
            $display("FAIL dis_trained got=%0b/%h exp=1/00000080",
                     pred_taken, pred_target);
        end
    endtask

    task automatic test_reset_drops_update();
        do_reset();
        do_update(32'h40, 1'b1, 32'h80, 1'b1);
        do_update(32'h40, 1'b1, 32'h80, 1'b1);
        rst        = 1'b0;
        upd_valid  = 1'b1;
        upd_pc     = 32'h40;
        upd_taken  = 1'b1;
        upd_target = 32'h80;
        upd_miss   = 1'b1;
        tick();
        rst       = 1'b1;
        upd_valid = 1'b0;
        lookup_pc = 32'h40;
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin
            n_fail++;
            $display("FAIL rst_upd_pred got=%0b/%h exp=0/00000044",
                     pred_taken, pred_target);
        end
        n_checks++;
        if (br_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_upd_perf got=%0d/%0d exp=0/0", br_cnt, miss_cnt);
        end
    endtask

    task automatic test_perf_saturation();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            do_update(32'h200 + 32'(i * 4), 1'b0, 32'h0, 1'b1);
        end
        #1;
        n_checks++;
        if (br_cnt4 !== 4'd15) begin
            n_fail++;
            $display("FAIL perf4_br_sat got=%0d exp=15", br_cnt4);
        end
        n_checks++;
        if (miss_cnt4 !== 4'd15) begin
            n_fail++;
            $display("FAIL perf4_miss_sat got=%0d exp=15", miss_cnt4);
        end
        n_checks++;
        if (br_cnt !== 32'd16) begin
            n_fail++;
            $display("FAIL perf32_br got=%0d exp=16", br_cnt);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        pred_en    = 1'b1;
        lookup_pc  = 32'h0;
        upd_valid  = 1'b0;
        upd_pc     = 32'h0;
        upd_taken  = 1'b0;
        upd_target = 32'h0;
        upd_miss   = 1'b0;
        tick();
        test_reset();
        test_train();
        test_saturate_hysteresis();
        test_alias();
        test_no_bypass();
        test_pred_disable();
        test_reset_drops_update();
        test_perf_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
